adc_emulator: RTL

Synthesizable SPI ADC responder that emulates the converter side of the link driven by `adc_manager`: it answers `cnv` with a `busy` pulse, accepts register-access commands on `spi_sdi`, and shifts samples out on one, two or four SDO lanes. Samples come from an AXI-Stream source, which lets the same bitstream drive `adc_manager` on hardware without a physical ADC. All SPI pins are oversampled in the `aclk` domain. `aclk` must run at least 4× the SPI clock.

---
 rtl/adc_emulator.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/adc_emulator.sv
// adc_emulator: SPI ADC responder driven by adc_manager. Answers cnv with a
// busy pulse, takes 24-bit register commands on spi_sdi and shifts
// AXI-Stream-sourced samples out on one, two or four SDO lanes. All SPI pins
// are oversampled in the aclk domain; aclk must be at least 4x the SPI clock.
// Optional feature macro: ADC_EMULATOR_RAMP_EN (fallback sample ramps by +1
// instead of repeating the last latched sample).
//
// Handshake: s_axis_tready is a one-cycle pulse in the first CONVERT cycle;
// a sample transfers only when s_axis_tvalid is high in that same cycle,
// otherwise the fallback sample is used for this conversion.
module adc_emulator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNV_CYCLES = 28
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  spi_clk,
  input  logic                  spi_csn,
  input  logic                  spi_sdi,
  input  logic                  spi_resetn,
  output logic [3:0]            spi_sdo,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [23:0]           reg_command,
  output logic                  reg_mode,
  output logic [1:0]            lane_mode,
  output logic                  dbg_state
);

  localparam int IDXW = $clog2(DATA_WIDTH + 1);
  localparam int CW   = $clog2(CNV_CYCLES);
  // Synchronizer bit order: {resetn, sdi, csn, clk, cnv}; idle pin levels.
  localparam logic [4:0] SYNC_RST = 5'b10100;

  typedef enum logic {S_IDLE = 1'b0, S_CONVERT = 1'b1} state_t;

  logic [4:0] sync1_q, sync2_q;
  logic [2:0] prev_q;
  logic       rst_int;
  logic       cnv_rise, sck_rise, csn_fall, csn_rise, csn_low, sdi_s;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            conv_done;

  logic [DATA_WIDTH-1:0] last_q, last_d, fallback;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic [IDXW-1:0]       idx_q, idx_d, step, nidx;
  logic                  rdy_q, rdy_d;
  logic [3:0]            sdo_q, sdo_d;

  logic [23:0] cmd_q, cmd_d, reg_command_q, reg_command_d;
  logic        reg_mode_q, reg_mode_d;
  logic [1:0]  lane_q, lane_d;

  // Two-flop synchronizers plus one edge register; only areset clears them
  // so a host-driven reset cannot mask its own release.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      prev_q  <= SYNC_RST[2:0];
    end else begin
      sync1_q <= {spi_resetn, spi_sdi, spi_csn, spi_clk, cnv};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[2:0];
    end
  end

  assign rst_int  = areset | ~sync2_q[4];
  assign cnv_rise = sync2_q[0] & ~prev_q[0];
  assign sck_rise = sync2_q[1] & ~prev_q[1];
  assign csn_fall = ~sync2_q[2] & prev_q[2];
  assign csn_rise = sync2_q[2] & ~prev_q[2];
  assign csn_low  = ~sync2_q[2];
  assign sdi_s    = sync2_q[3];

  // Conversion FSM state register and cycle counter.
  always_ff @(posedge aclk) begin
    if (rst_int) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Conversion FSM next state; cnv edges inside CONVERT are ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (cnv_rise) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (cnt_q == CW'(CNV_CYCLES - 1)) state_d = S_IDLE;
        else                               cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Conversion FSM outputs.
  always_comb begin
    busy          = (state_q == S_CONVERT);
    s_axis_tready = (state_q == S_CONVERT) && (cnt_q == '0);
    conv_done     = (state_q == S_CONVERT) && (cnt_q == CW'(CNV_CYCLES - 1));
    dbg_state     = state_q;
  end

`ifdef ADC_EMULATOR_RAMP_EN
  assign fallback = last_q + 1'b1;
`else
  assign fallback = last_q;
`endif

  // Sample capture in the tready cycle.
  always_comb begin
    last_d = last_q;
    if (s_axis_tready) last_d = s_axis_tvalid ? s_axis_tdata : fallback;
  end

  always_ff @(posedge aclk) begin
    if (rst_int) last_q <= '0;
    else         last_q <= last_d;
  end

  // Returns the SDO group starting at bit idx-1; lanes beyond the mode or
  // below bit 0 read 0.
  function automatic logic [3:0] group_bits(input logic [DATA_WIDTH-1:0] s,
                                            input logic [IDXW-1:0] idx,
                                            input logic [1:0] lm);
    logic [DATA_WIDTH-1:0] al;
    logic [3:0]            g;
    int                    n;
    al = s << (IDXW'(DATA_WIDTH) - idx);
    case (lm)
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 1;
    endcase
    g = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n && int'(idx) > k) g[k] = al[DATA_WIDTH-1-k];
    end
    return g;
  endfunction

  // Data shift: load on conversion exit wins over a same-cycle SCK edge.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    rdy_d = rdy_q;
    sdo_d = sdo_q;
    case (lane_q)
      2'b01:   step = IDXW'(2);
      2'b10:   step = IDXW'(4);
      default: step = IDXW'(1);
    endcase
    nidx = (idx_q > step) ? idx_q - step : '0;
    if (conv_done) begin
      sh_d  = last_q;
      idx_d = IDXW'(DATA_WIDTH);
      rdy_d = 1'b1;
      if (!reg_mode_q && csn_low)
        sdo_d = group_bits(last_q, IDXW'(DATA_WIDTH), lane_q);
    end else if (!reg_mode_q && csn_low && rdy_q) begin
      if (csn_fall) begin
        sdo_d = group_bits(sh_q, idx_q, lane_q);
      end else if (sck_rise) begin
        idx_d = nidx;
        if (nidx == '0) begin
          rdy_d = 1'b0;
          sdo_d = '0;
        end else begin
          sdo_d = group_bits(sh_q, nidx, lane_q);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (rst_int) begin
      sh_q  <= '0;
      idx_q <= '0;
      rdy_q <= 1'b0;
      sdo_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      rdy_q <= rdy_d;
      sdo_q <= sdo_d;
    end
  end

  // Command shift register and decode at CSN rise.
  always_comb begin
    cmd_d         = cmd_q;
    reg_command_d = reg_command_q;
    reg_mode_d    = reg_mode_q;
    lane_d        = lane_q;
    if (csn_fall)                cmd_d = '0;
    else if (csn_low && sck_rise) cmd_d = {cmd_q[22:0], sdi_s};
    if (csn_rise) begin
      reg_command_d = cmd_q;
      if (cmd_q[23:21] == 3'b101)
        reg_mode_d = 1'b1;
      else if (reg_mode_q && cmd_q[23:8] == 16'h0020)
        lane_d = cmd_q[7:6];
      else if (reg_mode_q && cmd_q[23:8] == 16'h0014 && cmd_q[0])
        reg_mode_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst_int) begin
      cmd_q         <= '0;
      reg_command_q <= '0;
      reg_mode_q    <= 1'b0;
      lane_q        <= 2'b00;
    end else begin
      cmd_q         <= cmd_d;
      reg_command_q <= reg_command_d;
      reg_mode_q    <= reg_mode_d;
      lane_q        <= lane_d;
    end
  end

  assign spi_sdo     = sdo_q;
  assign reg_command = reg_command_q;
  assign reg_mode    = reg_mode_q;
  assign lane_mode   = lane_q;

endmodule
